// File: rtl/param_universal_shift_register.sv
// Parametrised universal shift register: parallel load, logical/arithmetic shifts and rotates,
// sequenced one bit per clock under a start/busy/done handshake with a serial-out tap.
module param_universal_shift_register #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic             sin,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_SRL  = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ASR  = 3'b101;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_reg, state_next;
   logic [2:0]       op_reg, op_next;
   logic [AMT_W-1:0] cnt_reg, cnt_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic             sout_reg, sout_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         op_reg    <= OP_LOAD;
         cnt_reg   <= '0;
         q_reg     <= '0;
         sout_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         cnt_reg   <= cnt_next;
         q_reg     <= q_next;
         sout_reg  <= sout_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      cnt_next   = cnt_reg;
      q_next     = q_reg;
      sout_next  = sout_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               if (op == OP_LOAD) begin
                  q_next    = d;
                  done_next = 1'b1;
               end else if (op > OP_ASR || amt == '0) begin
                  // Reserved codes and zero-length shifts complete as a no-op.
                  done_next = 1'b1;
               end else begin
                  op_next    = op;
                  cnt_next   = amt;
                  busy_next  = 1'b1;
                  state_next = SHIFT;
               end
            end
         end

         SHIFT: begin
            case (op_reg)
               OP_SRL: begin
                  q_next    = {sin, q_reg[WIDTH-1:1]};
                  sout_next = q_reg[0];
               end
               OP_SLL: begin
                  q_next    = {q_reg[WIDTH-2:0], sin};
                  sout_next = q_reg[WIDTH-1];
               end
               OP_ROR: begin
                  q_next    = {q_reg[0], q_reg[WIDTH-1:1]};
                  sout_next = q_reg[0];
               end
               OP_ROL: begin
                  q_next    = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
                  sout_next = q_reg[WIDTH-1];
               end
               OP_ASR: begin
                  q_next    = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
                  sout_next = q_reg[0];
               end
               default: begin
                  q_next = q_reg;
               end
            endcase

            cnt_next = cnt_reg - AMT_W'(1);
            if (cnt_reg == AMT_W'(1)) begin
               state_next = IDLE;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign q    = q_reg;
   assign sout = sout_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench for param_universal_shift_register (WIDTH=8, AMT_W=4): load, shifts,
// rotates, back-to-back start, mid-operation reset and reserved opcode.
module tb_param_universal_shift_register;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] op;
   logic [3:0] amt;
   logic       sin;
   logic [7:0] d;
   logic [7:0] q;
   logic       sout;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] srl_exp [3] = '{8'hD2, 8'hE9, 8'hF4};
   logic [7:0] rst_exp [4] = '{8'hF2, 8'hF9, 8'hFC, 8'hFE};

   param_universal_shift_register #(.WIDTH(8), .AMT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .amt   (amt),
      .sin   (sin),
      .d     (d),
      .q     (q),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [7:0] val, input logic exp_sout);
      start = 1'b1; op = 3'b000; d = val; amt = 4'd7;
      tick();
      start = 1'b0;
      check("load_q", 32'(q), 32'(val));
      check("load_done", 32'(done), 32'd1);
      check("load_busy", 32'(busy), 32'd0);
      check("load_sout_hold", 32'(sout), 32'(exp_sout));
      tick();
      check("load_done_clr", 32'(done), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 3'b000; amt = 4'd0; sin = 1'b0; d = 8'h00;
      repeat (2) tick();
      check("rst_q", 32'(q), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sout", 32'(sout), 32'd0);
      rst_n = 1'b1;
      tick();

      do_load(8'hA5, 1'b0);

      // SRL by 3 with sin=1; op/amt changes during SHIFT must not matter
      start = 1'b1; op = 3'b001; amt = 4'd3; sin = 1'b1;
      tick();
      start = 1'b0; op = 3'b100; amt = 4'd9;
      check("srl_q_k", 32'(q), 32'hA5);
      check("srl_busy_k", 32'(busy), 32'd1);
      check("srl_done_k", 32'(done), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("srl_q", 32'(q), 32'(srl_exp[i]));
         check("srl_busy", 32'(busy), (i < 2) ? 32'd1 : 32'd0);
         check("srl_done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
      end
      check("srl_sout", 32'(sout), 32'd1);
      tick();
      check("srl_done_clr", 32'(done), 32'd0);

      do_load(8'h81, 1'b1);

      // ROL by 10 wraps to an effective rotate by 2; mid-op LOAD request is ignored
      start = 1'b1; op = 3'b100; amt = 4'd10;
      tick();
      start = 1'b0;
      check("rol_busy_k", 32'(busy), 32'd1);
      for (int i = 1; i <= 10; i++) begin
         if (i == 3) begin
            start = 1'b1; op = 3'b000; d = 8'hFF;
         end else begin
            start = 1'b0;
         end
         tick();
         if (i == 1) check("rol_q1", 32'(q), 32'h03);
         check("rol_busy", 32'(busy), (i < 10) ? 32'd1 : 32'd0);
         check("rol_done", 32'(done), (i == 10) ? 32'd1 : 32'd0);
      end
      check("rol_q", 32'(q), 32'h06);
      check("rol_sout", 32'(sout), 32'd0);
      tick();
      check("rol_done_clr", 32'(done), 32'd0);

      do_load(8'h90, 1'b0);

      // ASR by 2, then a zero-length SLL started in the done cycle
      start = 1'b1; op = 3'b101; amt = 4'd2; sin = 1'b0;
      tick();
      start = 1'b0;
      tick();
      check("asr_q1", 32'(q), 32'hC8);
      check("asr_done1", 32'(done), 32'd0);
      tick();
      check("asr_q2", 32'(q), 32'hE4);
      check("asr_sout", 32'(sout), 32'd0);
      check("asr_done", 32'(done), 32'd1);
      start = 1'b1; op = 3'b010; amt = 4'd0; sin = 1'b1;
      tick();
      start = 1'b0;
      check("sll0_q", 32'(q), 32'hE4);
      check("sll0_done", 32'(done), 32'd1);
      check("sll0_busy", 32'(busy), 32'd0);
      tick();
      check("sll0_done_clr", 32'(done), 32'd0);

      // SRL by 15 aborted by reset after four steps
      start = 1'b1; op = 3'b001; amt = 4'd15; sin = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("abort_q", 32'(q), 32'(rst_exp[i]));
      end
      check("abort_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_q_rst", 32'(q), 32'h00);
      check("abort_busy_rst", 32'(busy), 32'd0);
      check("abort_sout_rst", 32'(sout), 32'd0);
      check("abort_done_rst", 32'(done), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("abort_done_hold", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      tick();
      check("post_rst_done", 32'(done), 32'd0);
      do_load(8'h3C, 1'b0);

      // Reserved opcode behaves as a no-op with a single done pulse
      start = 1'b1; op = 3'b111; amt = 4'd5;
      tick();
      start = 1'b0;
      check("rsv_q", 32'(q), 32'h3C);
      check("rsv_busy", 32'(busy), 32'd0);
      check("rsv_done", 32'(done), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rsv_done_clr", 32'(done), 32'd0);
         check("rsv_busy_idle", 32'(busy), 32'd0);
         check("rsv_q_hold", 32'(q), 32'h3C);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/param_universal_shift_register.md
Name: param_universal_shift_register

Overview:
- Parametrised N-bit universal shift register. Successor to the team's 4-bit bidirectional shift register.
- Adds the following over that block:
  - multi-position shifts sequenced one bit per clock under a start/busy/done handshake;
  - rotate and arithmetic-shift modes;
  - serial-out tap.
- Used as a serialiser/alignment element in datapath exercises; driven by a controller FSM or a bench.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 4, width of shift-amount input; max shift = 2^AMT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request operation; sampled only in IDLE.
- op  input  3  operation code:
  - 000 LOAD
  - 001 SRL (right, sin into MSB)
  - 010 SLL (left, sin into LSB)
  - 011 ROR
  - 100 ROL
  - 101 ASR (right, MSB replicated)
  - 110/111 reserved
- amt  input  AMT_W  number of single-bit shift steps.
- sin  input  1  serial input for SRL/SLL; sampled on every shift edge.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout  output  1  bit expelled/wrapped by the most recent shift step.
- busy  output  1  high while shift steps are pending.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, rst_n=0): q=0, sout=0, busy=0, done=0, state=IDLE, internal counter=0. Reset asserted mid-operation aborts it immediately; no done pulse.
- States: IDLE, SHIFT.
- done defaults to 0 every edge unless set below.
- IDLE, start=1 at edge k:
  - op=LOAD: q<=d at edge k; done=1 for the cycle after edge k; busy stays 0; amt ignored.
  - Shift/rotate op with amt=0: q unchanged; done=1 after edge k; stay IDLE.
  - Reserved op: same as amt=0 (no-op, done pulse).
  - Otherwise: latch op, cnt<=amt, busy<=1, state<=SHIFT; q unchanged at edge k.
- SHIFT, each edge:
  - Perform one step per latched op. Update sout:
    - SRL/ROR/ASR: sout = old q[0].
    - SLL/ROL: sout = old q[WIDTH-1].
  - Step data:
    - SRL: {sin, q[W-1:1]}
    - SLL: {q[W-2:0], sin}
    - ROR: {q[0], q[W-1:1]}
    - ROL: {q[W-2:0], q[W-1]}
    - ASR: {q[W-1], q[W-1:1]}
  - cnt<=cnt-1. When cnt==1 on this edge: state<=IDLE, busy<=0, done<=1.
- Latency: q changes on edges k+1..k+amt; busy high for exactly amt cycles; done high the cycle after edge k+amt.
- Handshake rules:
  - start while busy is ignored; op/amt/d changes during SHIFT have no effect.
  - sin is live in every SHIFT cycle (streaming).
  - start asserted in the done cycle (state=IDLE) is accepted; back-to-back operations are permitted.
- amt >= WIDTH is legal:
  - rotates wrap (effective amt mod WIDTH, but still takes amt cycles);
  - SRL/SLL fill entirely with the sin stream;
  - ASR saturates to all sign bits.
- sout holds its value in IDLE and on LOAD.

Test Plan (WIDTH=8, AMT_W=4):
- LOAD d=8'hA5 -> q=8'hA5 one edge after start; done high 1 cycle; busy never asserts.
- From q=8'hA5, op=SRL amt=3 sin=1 -> busy 3 cycles; q sequence D2, E9, F4; final q=8'hF4, sout=1; done pulse after 3rd shift.
- From q=8'h81, op=ROL amt=10 -> busy 10 cycles; final q=8'h06, sout=0; mid-op start with op=LOAD d=8'hFF ignored.
- From q=8'h90, op=ASR amt=2 sin=0 -> q=8'hC8 then 8'hE4; sout=0; done after 2nd shift. Then start op=SLL amt=0 in the done cycle -> accepted; q stays E4; done pulses next cycle.
- Start SRL amt=15; drop rst_n after 4 shifts -> q=0, busy=0, sout=0 immediately; no done pulse; after release, LOAD 8'h3C works normally.
- op=3'b111 amt=5 -> q unchanged; busy stays 0; done pulses once.
